// File: rtl/wb_initiator_seq_if.sv
// rtl/wb_initiator_seq_if.sv - command/response streams and Wishbone master bus of wb_initiator_seq
//
// Groups every handshake and bus signal of the initiator:
//   cmd_*  : valid/ready command stream (we, byte address, byte enables, write data)
//   rsp_*  : valid/ready response stream (read data, timeout error, we echo)
//   WBm_*  : Wishbone classic master outputs plus responder data/ack inputs
// Modport master is the initiator itself; modport slave is the environment around it
// (command source, response sink and Wishbone responder).
interface wb_initiator_seq_if #(
  parameter int ADDRWIDTH = 17,
  parameter int DATAWIDTH = 32
);
  localparam int STBWIDTH = DATAWIDTH / 8;

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_we_i;
  logic [ADDRWIDTH-1:0] cmd_adr_i;
  logic [STBWIDTH-1:0]  cmd_byte_stb_i;
  logic [DATAWIDTH-1:0] cmd_dat_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DATAWIDTH-1:0] rsp_rdata_o;
  logic                 rsp_err_o;
  logic                 rsp_we_o;

  logic [ADDRWIDTH-1:0] WBm_ADR_o;
  logic                 WBm_CYC_o;
  logic                 WBm_STB_o;
  logic                 WBm_WE_o;
  logic                 WBm_RD_o;
  logic [STBWIDTH-1:0]  WBm_BYTE_STB_o;
  logic [DATAWIDTH-1:0] WBm_DAT_o;
  logic [DATAWIDTH-1:0] WBm_DAT_i;
  logic                 WBm_ACK_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_byte_stb_i, cmd_dat_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_we_o,
    output WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o, WBm_BYTE_STB_o, WBm_DAT_o,
    input  WBm_DAT_i, WBm_ACK_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_byte_stb_i, cmd_dat_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_we_o,
    input  WBm_ADR_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o, WBm_BYTE_STB_o, WBm_DAT_o,
    output WBm_DAT_i, WBm_ACK_i
  );
endinterface

// File: rtl/wb_initiator_seq.sv
// rtl/wb_initiator_seq.sv - single-cycle Wishbone classic initiator driven by a command stream
//
// Ports:
//   WBs_CLK_i : the only clock
//   WBs_RST_i : synchronous active-high reset
//   bus       : wb_initiator_seq_if.master (cmd stream in, rsp stream out, Wishbone master)
// One transaction is outstanding at a time: IDLE accepts a command, BUS runs the
// Wishbone cycle until ACK or timeout, RESP holds the response until it is taken.
// Every output, including cmd_ready_o, comes straight from a register.
module wb_initiator_seq #(
  parameter int                    ADDRWIDTH          = 17,
  parameter int                    DATAWIDTH          = 32,
  parameter int                    CNTR_WIDTH         = 8,
  parameter int                    TIMEOUT_CYCLES     = 255,
  parameter logic [DATAWIDTH-1:0]  DEFAULT_READ_VALUE = 32'hBADFABAC
) (
  input logic                  WBs_CLK_i,
  input logic                  WBs_RST_i,
  wb_initiator_seq_if.master   bus
);

  // Counter value seen on the last permitted BUS cycle: the counter starts at 0 on the
  // first BUS cycle, so CYC stays high for exactly TIMEOUT_CYCLES clocks.
  localparam logic [CNTR_WIDTH-1:0] TIMEOUT_LAST = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [CNTR_WIDTH-1:0] cntr;

  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state              <= IDLE;
      cntr               <= '0;
      bus.cmd_ready_o    <= 1'b0;
      bus.rsp_valid_o    <= 1'b0;
      bus.rsp_rdata_o    <= '0;
      bus.rsp_err_o      <= 1'b0;
      bus.rsp_we_o       <= 1'b0;
      bus.WBm_ADR_o      <= '0;
      bus.WBm_CYC_o      <= 1'b0;
      bus.WBm_STB_o      <= 1'b0;
      bus.WBm_WE_o       <= 1'b0;
      bus.WBm_RD_o       <= 1'b0;
      bus.WBm_BYTE_STB_o <= '0;
      bus.WBm_DAT_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i && bus.cmd_ready_o) begin
            bus.cmd_ready_o    <= 1'b0;
            bus.WBm_ADR_o      <= bus.cmd_adr_i;
            bus.WBm_BYTE_STB_o <= bus.cmd_byte_stb_i;
            bus.WBm_DAT_o      <= bus.cmd_dat_i;
            bus.WBm_WE_o       <= bus.cmd_we_i;
            bus.WBm_RD_o       <= ~bus.cmd_we_i;
            bus.WBm_CYC_o      <= 1'b1;
            bus.WBm_STB_o      <= 1'b1;
            cntr               <= '0;
            state              <= BUS;
          end else begin
            // Also raises ready on the first clock after reset releases.
            bus.cmd_ready_o <= 1'b1;
          end
        end

        BUS: begin
          // ACK is checked first so it wins over a timeout landing on the same clock.
          if (bus.WBm_ACK_i) begin
            bus.rsp_rdata_o <= bus.WBm_WE_o ? '0 : bus.WBm_DAT_i;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_we_o    <= bus.WBm_WE_o;
            bus.rsp_valid_o <= 1'b1;
            bus.WBm_CYC_o   <= 1'b0;
            bus.WBm_STB_o   <= 1'b0;
            bus.WBm_WE_o    <= 1'b0;
            bus.WBm_RD_o    <= 1'b0;
            state           <= RESP;
          end else if (cntr == TIMEOUT_LAST) begin
            bus.rsp_rdata_o <= DEFAULT_READ_VALUE;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_we_o    <= bus.WBm_WE_o;
            bus.rsp_valid_o <= 1'b1;
            bus.WBm_CYC_o   <= 1'b0;
            bus.WBm_STB_o   <= 1'b0;
            bus.WBm_WE_o    <= 1'b0;
            bus.WBm_RD_o    <= 1'b0;
            state           <= RESP;
          end else begin
            cntr <= cntr + 1'b1;
          end
        end

        RESP: begin
          // ACK is not looked at here, so a stray acknowledge cannot disturb the response.
          if (bus.rsp_ready_i) begin
            bus.rsp_valid_o <= 1'b0;
            bus.cmd_ready_o <= 1'b1;
            state           <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator_seq.sv
// tb/tb_wb_initiator_seq.sv - directed self-checking bench for wb_initiator_seq
module tb_wb_initiator_seq;

  logic clk;
  logic rst;

  int vectors;
  int errs;
  int n;

  wb_initiator_seq_if #(.ADDRWIDTH(17), .DATAWIDTH(32)) bi  ();
  wb_initiator_seq_if #(.ADDRWIDTH(17), .DATAWIDTH(32)) bi4 ();

  wb_initiator_seq #(.TIMEOUT_CYCLES(7)) u_dut (
    .WBs_CLK_i (clk),
    .WBs_RST_i (rst),
    .bus       (bi)
  );

  wb_initiator_seq #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .WBs_CLK_i (clk),
    .WBs_RST_i (rst),
    .bus       (bi4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    rst     = 1'b1;
    bi.cmd_valid_i = 1'b0;  bi.cmd_we_i = 1'b0;  bi.cmd_adr_i = '0;
    bi.cmd_byte_stb_i = '0; bi.cmd_dat_i = '0;   bi.rsp_ready_i = 1'b0;
    bi.WBm_DAT_i = '0;      bi.WBm_ACK_i = 1'b0;
    bi4.cmd_valid_i = 1'b0; bi4.cmd_we_i = 1'b0; bi4.cmd_adr_i = '0;
    bi4.cmd_byte_stb_i = '0; bi4.cmd_dat_i = '0; bi4.rsp_ready_i = 1'b0;
    bi4.WBm_DAT_i = '0;     bi4.WBm_ACK_i = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_cyc",       bi.WBm_CYC_o,      0);
    chk("rst_stb",       bi.WBm_STB_o,      0);
    chk("rst_adr",       bi.WBm_ADR_o,      0);
    chk("rst_dat",       bi.WBm_DAT_o,      0);
    chk("rst_rsp_valid", bi.rsp_valid_o,    0);
    chk("rst_rsp_rdata", bi.rsp_rdata_o,    0);
    chk("rst_rsp_err",   bi.rsp_err_o,      0);
    chk("rst_cmd_ready", bi.cmd_ready_o,    0);
    rst = 1'b0;
    tick;
    chk("idle_cmd_ready", bi.cmd_ready_o,   1);

    // Write, ACK on the second STB clock
    bi.cmd_valid_i = 1'b1; bi.cmd_we_i = 1'b1; bi.cmd_adr_i = 17'h04004;
    bi.cmd_byte_stb_i = 4'hF; bi.cmd_dat_i = 32'hA5A5_0001;
    tick;
    bi.cmd_valid_i = 1'b0;
    chk("wr_cyc1",  bi.WBm_CYC_o,      1);
    chk("wr_stb1",  bi.WBm_STB_o,      1);
    chk("wr_we",    bi.WBm_WE_o,       1);
    chk("wr_rd",    bi.WBm_RD_o,       0);
    chk("wr_adr",   bi.WBm_ADR_o,      17'h04004);
    chk("wr_bstb",  bi.WBm_BYTE_STB_o, 4'hF);
    chk("wr_dat",   bi.WBm_DAT_o,      32'hA5A5_0001);
    chk("wr_ready", bi.cmd_ready_o,    0);
    tick;
    chk("wr_cyc2",  bi.WBm_CYC_o,      1);
    bi.WBm_ACK_i = 1'b1; bi.WBm_DAT_i = 32'hDEAD_BEEF;
    tick;
    bi.WBm_ACK_i = 1'b0;
    chk("wr_cyc3",       bi.WBm_CYC_o,   0);
    chk("wr_stb3",       bi.WBm_STB_o,   0);
    chk("wr_rsp_valid",  bi.rsp_valid_o, 1);
    chk("wr_rsp_rdata",  bi.rsp_rdata_o, 0);
    chk("wr_rsp_err",    bi.rsp_err_o,   0);
    chk("wr_rsp_we",     bi.rsp_we_o,    1);
    bi.rsp_ready_i = 1'b1;
    tick;
    bi.rsp_ready_i = 1'b0;
    chk("wr_rsp_done",   bi.rsp_valid_o, 0);
    chk("wr_ready_back", bi.cmd_ready_o, 1);

    // Read with wait states: ACK on the 6th BUS clock
    bi.cmd_valid_i = 1'b1; bi.cmd_we_i = 1'b0; bi.cmd_adr_i = 17'h05000;
    bi.cmd_byte_stb_i = 4'hF; bi.cmd_dat_i = 32'h0;
    tick;
    bi.cmd_valid_i = 1'b0;
    chk("rd_adr", bi.WBm_ADR_o, 17'h05000);
    chk("rd_we",  bi.WBm_WE_o,  0);
    for (int i = 1; i <= 5; i++) begin
      chk("rd_rd_held",  bi.WBm_RD_o,  1);
      chk("rd_cyc_held", bi.WBm_CYC_o, 1);
      tick;
    end
    chk("rd_rd_last", bi.WBm_RD_o, 1);
    bi.WBm_ACK_i = 1'b1; bi.WBm_DAT_i = 32'h0100_0000;
    tick;
    bi.WBm_ACK_i = 1'b0; bi.WBm_DAT_i = 32'h0;
    chk("rd_cyc_drop",   bi.WBm_CYC_o,   0);
    chk("rd_rsp_valid",  bi.rsp_valid_o, 1);
    chk("rd_rsp_rdata",  bi.rsp_rdata_o, 32'h0100_0000);
    chk("rd_rsp_err",    bi.rsp_err_o,   0);
    chk("rd_rsp_we",     bi.rsp_we_o,    0);

    // Back-pressure on that response with a new command waiting and a stray ACK
    bi.cmd_valid_i = 1'b1; bi.cmd_we_i = 1'b1; bi.cmd_adr_i = 17'h00100;
    bi.cmd_byte_stb_i = 4'h3; bi.cmd_dat_i = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      bi.WBm_ACK_i = (i == 4);
      bi.WBm_DAT_i = (i == 4) ? 32'hFFFF_FFFF : 32'h0;
      tick;
      chk("bp_rsp_valid", bi.rsp_valid_o, 1);
      chk("bp_rsp_rdata", bi.rsp_rdata_o, 32'h0100_0000);
      chk("bp_rsp_err",   bi.rsp_err_o,   0);
      chk("bp_cmd_ready", bi.cmd_ready_o, 0);
      chk("bp_cyc",       bi.WBm_CYC_o,   0);
    end
    bi.WBm_ACK_i = 1'b0; bi.WBm_DAT_i = 32'h0;
    bi.rsp_ready_i = 1'b1;
    tick;
    bi.rsp_ready_i = 1'b0;
    chk("bp_rsp_done",  bi.rsp_valid_o, 0);
    chk("bp_ready_r1",  bi.cmd_ready_o, 1);
    chk("bp_cyc_r1",    bi.WBm_CYC_o,   0);
    tick;
    bi.cmd_valid_i = 1'b0;
    chk("bp_next_cyc",  bi.WBm_CYC_o,   1);
    chk("bp_next_adr",  bi.WBm_ADR_o,   17'h00100);
    chk("bp_next_bstb", bi.WBm_BYTE_STB_o, 4'h3);
    chk("bp_next_dat",  bi.WBm_DAT_o,   32'h1111_2222);
    bi.WBm_ACK_i = 1'b1;
    tick;
    bi.WBm_ACK_i = 1'b0;
    chk("bp_next_rsp",  bi.rsp_valid_o, 1);
    chk("bp_next_we",   bi.rsp_we_o,    1);
    bi.rsp_ready_i = 1'b1;
    tick;
    bi.rsp_ready_i = 1'b0;

    // Timeout with TIMEOUT_CYCLES=7
    bi.cmd_valid_i = 1'b1; bi.cmd_we_i = 1'b0; bi.cmd_adr_i = 17'h00008;
    bi.cmd_byte_stb_i = 4'hF;
    tick;
    bi.cmd_valid_i = 1'b0;
    n = 0;
    while (bi.WBm_CYC_o === 1'b1 && n < 20) begin
      n++;
      tick;
    end
    chk("to_cyc_clocks", n, 7);
    chk("to_rsp_valid",  bi.rsp_valid_o, 1);
    chk("to_rsp_err",    bi.rsp_err_o,   1);
    chk("to_rsp_rdata",  bi.rsp_rdata_o, 32'hBADF_ABAC);
    bi.rsp_ready_i = 1'b1;
    tick;
    bi.rsp_ready_i = 1'b0;
    bi.cmd_valid_i = 1'b1; bi.cmd_adr_i = 17'h0000C;
    tick;
    bi.cmd_valid_i = 1'b0;
    bi.WBm_ACK_i = 1'b1; bi.WBm_DAT_i = 32'hCAFE_F00D;
    tick;
    bi.WBm_ACK_i = 1'b0; bi.WBm_DAT_i = 32'h0;
    chk("to_next_valid", bi.rsp_valid_o, 1);
    chk("to_next_err",   bi.rsp_err_o,   0);
    chk("to_next_rdata", bi.rsp_rdata_o, 32'hCAFE_F00D);
    bi.rsp_ready_i = 1'b1;
    tick;
    bi.rsp_ready_i = 1'b0;

    // Reset on the 3rd clock of a pending read
    bi.cmd_valid_i = 1'b1; bi.cmd_adr_i = 17'h00010;
    tick;
    bi.cmd_valid_i = 1'b0;
    tick;
    tick;
    chk("rb_cyc_before", bi.WBm_CYC_o, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rb_cyc",       bi.WBm_CYC_o,   0);
    chk("rb_stb",       bi.WBm_STB_o,   0);
    chk("rb_rsp_valid", bi.rsp_valid_o, 0);
    chk("rb_cmd_ready", bi.cmd_ready_o, 0);
    tick;
    chk("rb_ready_after", bi.cmd_ready_o, 1);
    chk("rb_no_rsp",      bi.rsp_valid_o, 0);
    tick;
    chk("rb_no_rsp2",     bi.rsp_valid_o, 0);

    // TIMEOUT_CYCLES=4: plain timeout, then ACK on the 4th CYC clock
    bi4.cmd_valid_i = 1'b1; bi4.cmd_we_i = 1'b0; bi4.cmd_adr_i = 17'h00020;
    bi4.cmd_byte_stb_i = 4'hF;
    tick;
    bi4.cmd_valid_i = 1'b0;
    n = 0;
    while (bi4.WBm_CYC_o === 1'b1 && n < 20) begin
      n++;
      tick;
    end
    chk("t4_cyc_clocks", n, 4);
    chk("t4_rsp_err",    bi4.rsp_err_o, 1);
    bi4.rsp_ready_i = 1'b1;
    tick;
    bi4.rsp_ready_i = 1'b0;
    bi4.cmd_valid_i = 1'b1;
    tick;
    bi4.cmd_valid_i = 1'b0;
    tick;
    tick;
    tick;
    chk("col_cyc4", bi4.WBm_CYC_o, 1);
    bi4.WBm_ACK_i = 1'b1; bi4.WBm_DAT_i = 32'h1234_5678;
    tick;
    bi4.WBm_ACK_i = 1'b0; bi4.WBm_DAT_i = 32'h0;
    chk("col_rsp_valid", bi4.rsp_valid_o, 1);
    chk("col_rsp_err",   bi4.rsp_err_o,   0);
    chk("col_rsp_rdata", bi4.rsp_rdata_o, 32'h1234_5678);
    chk("col_cyc_drop",  bi4.WBm_CYC_o,   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
